// File: rtl/eq_ctrl_pkg.sv
// eq_ctrl_pkg: shared state encoding and client ids for the serial equality arbiter
package eq_ctrl_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;
endpackage

// File: rtl/eq2_cell.sv
// eq2_cell: combinational 2-bit equality written as a sum of products
module eq2_cell (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq
);
    // true for each of the four matching bit patterns
    always_comb begin
        eq = (~a[1] & ~b[1] & ~a[0] & ~b[0])
           | (~a[1] & ~b[1] &  a[0] &  b[0])
           | ( a[1] &  b[1] & ~a[0] & ~b[0])
           | ( a[1] &  b[1] &  a[0] &  b[0]);
    end
endmodule

// File: rtl/eq_serial_arb.sv
// eq_serial_arb: round-robin shared serial equality engine, 2 bits per cycle, early exit on mismatch
module eq_serial_arb
    import eq_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         aeqb,
    output logic         busy
);
    localparam int S = W / 2;
    localparam int CW = (S > 1) ? $clog2(S) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(S - 1);

    logic [1:0]    state;
    logic [W-1:0]  sh_a;
    logic [W-1:0]  sh_b;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          last;
    logic          eq_slice;
    logic          win;

    eq2_cell u_eq2 (
        .a  (sh_a[1:0]),
        .b  (sh_b[1:0]),
        .eq (eq_slice)
    );

    // winner: the lone requester, or the one that was not served last
    always_comb begin
        win = (req0 & req1) ? ~last : req1;
    end

    // arbitration, serial compare and result capture; aeqb only moves on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            owner <= CLIENT0;
            last  <= CLIENT1;
            aeqb  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0 | req1) begin
                    sh_a  <= win ? a1 : a0;
                    sh_b  <= win ? b1 : b0;
                    cnt   <= '0;
                    owner <= win;
                    last  <= win;
                    state <= CMP;
                end
                CMP: if (!eq_slice || cnt == LAST_SLICE) begin
                    aeqb  <= eq_slice;
                    state <= DONE;
                end else begin
                    sh_a <= sh_a >> 2;
                    sh_b <= sh_b >> 2;
                    cnt  <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // grant pulses on the first CMP cycle, done pulses in DONE, both steered by owner
    always_comb begin
        gnt0  = (state == CMP) && (cnt == '0) && (owner == CLIENT0);
        gnt1  = (state == CMP) && (cnt == '0) && (owner == CLIENT1);
        done0 = (state == DONE) && (owner == CLIENT0);
        done1 = (state == DONE) && (owner == CLIENT1);
        busy  = (state != IDLE);
    end
endmodule

// File: doc/eq_serial_arb.md
Name: eq_serial_arb

Overview:
- Shared serial equality engine that arbitrates between two requesters.
- Compares each granted W-bit operand pair 2 bits per cycle, LSB slice first, using one combinational 2-bit equality cell.
- Stops early on the first mismatching slice.
- Sits between client blocks that need occasional wide equality checks and a single small comparator resource.

Parameters:
- W, 8, operand width in bits; must be even and >= 2; number of slices S = W/2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  client 0 request (level).
- a0  input  W  client 0 operand A.
- b0  input  W  client 0 operand B.
- req1  input  1  client 1 request (level).
- a1  input  W  client 1 operand A.
- b1  input  W  client 1 operand B.
- gnt0  output  1  one-cycle pulse: client 0 operands have been captured.
- gnt1  output  1  one-cycle pulse: client 1 operands have been captured.
- done0  output  1  one-cycle pulse: client 0 result valid on aeqb.
- done1  output  1  one-cycle pulse: client 1 result valid on aeqb.
- aeqb  output  1  comparison result (1 = equal); held until the next done.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE; gnt0, gnt1, done0, done1, aeqb, busy all 0; slice counter 0; round-robin pointer last=1, so client 0 wins the first contest.
- Reset mid-operation: the current comparison is discarded and no done is issued. Outputs are 0 in the cycle after the reset edge.
- States: IDLE, CMP, DONE.
- IDLE, no request: remain in IDLE.
- IDLE, any request:
  - Select the winner: if only one req is high, that client; if both, the client != last.
  - On that edge, load the winner's a/b into shift registers, clear the counter, record the owner, set last = owner, go to CMP.
  - Operands must be stable in the cycle req is sampled.
- CMP, first cycle: gnt<owner> = 1 for exactly one cycle.
- CMP, each cycle: the eq2 cell compares shA[1:0] vs shB[1:0].
  - Mismatch: result = 0, go to DONE (early exit).
  - Match and counter == S-1: result = 1, go to DONE.
  - Otherwise: shift both registers right by 2, counter + 1.
- DONE: done<owner> = 1 for one cycle; aeqb = result (registered, holds until overwritten at the next DONE); go to IDLE.
- Latency (req sampled at the end of cycle T):
  - gnt in T+1.
  - Full match: done in T+S+1 (W=8: T+5).
  - Mismatch in slice k (0-based): done in T+k+2.
- Throughput: one IDLE cycle between jobs; no arbitration in DONE.
- A request arriving while busy waits; req changes while busy have no effect.
- A client holding req after its done is treated as a new request. It loses to the other client if both are requesting.
- gnt and done never assert for both clients in the same cycle; a gnt and a done are never high together.
- The counter width is clog2(S), minimum 1.

Decomposition:
- Shared package eq_ctrl_pkg holds:
  - state encoding constants (IDLE=2'd0, CMP=2'd1, DONE=2'd2);
  - the client id constants.
- One sub-module, eq2_cell: purely combinational.
  - Inputs: 2-bit a and 2-bit b.
  - Output: eq = (a == b), as a sum of products.
  - Instantiated once, on the shift-register LSBs.

Test Plan:
- Reset; req0 with a0=b0=8'hA5 -> gnt0 in T+1; done0 in T+5; aeqb=1; busy high T+1..T+5.
- req0 with a0=8'hA5, b0=8'hA4 -> mismatch in slice 0; done0 in T+2; aeqb=0; only one CMP cycle.
- req1 with a1=8'h25, b1=8'hA5 -> mismatch in slice 3; done1 in T+5; aeqb=0; gnt0/done0 never assert.
- Reset; req0 and req1 both held high with equal operands -> order gnt0, done0, IDLE, gnt1, done1, IDLE, gnt0 (strict alternation); aeqb=1 at each done.
- reset pulsed in the second CMP cycle of a req0 job -> no done0; all outputs 0 the next cycle; a later req1 (8'h3C vs 8'h3C) completes normally with aeqb=1 and client 1 served.
- After an equal job (aeqb=1), a mismatch job runs -> aeqb stays 1 through that job's CMP cycles and changes to 0 only in its DONE cycle.
